// File: rtl/branch_resolve_unit.sv
// Branch resolve unit.
// Carries each fetched branch prediction (taken bit and predicted target) through the F->D and
// D->E pipeline registers. In EX it compares the prediction against the resolved outcome and
// produces the misprediction flushes, the corrected fetch PC, a registered training update for
// the 2-bit predictor, and saturating performance counters.
//
// Ports:
//   i_clk, i_reset      core clock, synchronous active-high reset
//   i_pc_f, i_valid_f   IF instruction PC and valid
//   i_pred_taken_f      predictor direction for the IF instruction
//   i_pred_target_f     predicted target (meaningful when i_pred_taken_f=1)
//   i_stall_d           hold the F->D register
//   i_flush_e_in        insert a bubble into EX (load-use)
//   i_branch_e          EX instruction is a conditional branch
//   i_taken_e           resolved branch condition
//   i_target_e          resolved branch target
//   o_mispredict_e      EX branch mispredicted (combinational)
//   o_flush_d           kill the ID instruction
//   o_flush_e           kill the EX-bound instruction
//   o_redirect_pc       corrected fetch PC, 0 unless o_mispredict_e
//   o_upd_valid         a branch resolved last cycle
//   o_branch_taken      last resolved outcome, held across non-branch cycles
//   o_branch_cnt        resolved branches, saturating
//   o_mispred_cnt       mispredictions, saturating
module branch_resolve_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [XLEN-1:0]  i_pc_f,
    input  logic             i_pred_taken_f,
    input  logic [XLEN-1:0]  i_pred_target_f,
    input  logic             i_valid_f,
    input  logic             i_stall_d,
    input  logic             i_flush_e_in,
    input  logic             i_branch_e,
    input  logic             i_taken_e,
    input  logic [XLEN-1:0]  i_target_e,
    output logic             o_mispredict_e,
    output logic             o_flush_d,
    output logic             o_flush_e,
    output logic [XLEN-1:0]  o_redirect_pc,
    output logic             o_upd_valid,
    output logic             o_branch_taken,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    logic            r_valid_d;
    logic [XLEN-1:0] r_pc_d;
    logic            r_pred_d;
    logic [XLEN-1:0] r_tgt_d;

    logic            r_valid_e;
    logic [XLEN-1:0] r_pc_e;
    logic            r_pred_e;
    logic [XLEN-1:0] r_tgt_e;

    logic             r_upd_valid;
    logic             r_branch_taken;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic            w_resolve;
    logic            w_mispredict;
    logic [XLEN-1:0] w_pc_plus4;

    // EX-stage branch inputs are only meaningful for a live instruction.
    assign w_resolve    = r_valid_e & i_branch_e;
    // A taken/taken match still mispredicts if the predicted target was wrong.
    assign w_mispredict = w_resolve & ((i_taken_e != r_pred_e) |
                                       (i_taken_e & r_pred_e & (i_target_e != r_tgt_e)));
    assign w_pc_plus4   = r_pc_e + XLEN'(4);

    always_comb begin
        o_redirect_pc = '0;
        if (w_mispredict) begin
            o_redirect_pc = i_taken_e ? i_target_e : w_pc_plus4;
        end
    end

    assign o_mispredict_e = w_mispredict;
    assign o_flush_d      = w_mispredict;
    assign o_flush_e      = w_mispredict | i_flush_e_in;

    // F->D register: mispredict beats stall.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid_d <= 1'b0;
            r_pc_d    <= '0;
            r_pred_d  <= 1'b0;
            r_tgt_d   <= '0;
        end else if (w_mispredict) begin
            r_valid_d <= 1'b0;
        end else if (!i_stall_d) begin
            r_valid_d <= i_valid_f;
            r_pc_d    <= i_pc_f;
            r_pred_d  <= i_pred_taken_f;
            r_tgt_d   <= i_pred_target_f;
        end
    end

    // D->E register: stall alone still copies D; the hazard unit pairs it with a bubble.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid_e <= 1'b0;
            r_pc_e    <= '0;
            r_pred_e  <= 1'b0;
            r_tgt_e   <= '0;
        end else if (w_mispredict || i_flush_e_in) begin
            r_valid_e <= 1'b0;
        end else begin
            r_valid_e <= r_valid_d;
            r_pc_e    <= r_pc_d;
            r_pred_e  <= r_pred_d;
            r_tgt_e   <= r_tgt_d;
        end
    end

    // Training output holds across bubbles: the predictor samples it every cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_upd_valid    <= 1'b0;
            r_branch_taken <= 1'b0;
            r_branch_cnt   <= '0;
            r_mispred_cnt  <= '0;
        end else begin
            r_upd_valid <= w_resolve;
            if (w_resolve) begin
                r_branch_taken <= i_taken_e;
            end
            if (w_resolve && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_mispredict && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
        end
    end

    assign o_upd_valid    = r_upd_valid;
    assign o_branch_taken = r_branch_taken;
    assign o_branch_cnt   = r_branch_cnt;
    assign o_mispred_cnt  = r_mispred_cnt;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Downstream companion of the 2-bit branch predictor in the pipelined RISC-V core. Carries each fetched prediction (taken bit and predicted target) from IF through ID into EX and compares it with the resolved outcome. Generates misprediction flushes, the corrected fetch PC, a registered training update for the predictor, and saturating performance counters.

Parameters:
XLEN, 32, PC/target width
CNT_W, 16, width of branch and mispredict performance counters

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
pc_f  in  XLEN  PC of instruction in IF
pred_taken_f  in  1  predictor output for instruction in IF
pred_target_f  in  XLEN  predicted target, meaningful when pred_taken_f=1
valid_f  in  1  IF holds a real instruction
stall_d  in  1  hazard unit: hold F->D register
flush_e_in  in  1  hazard unit: insert bubble into E (load-use)
branch_e  in  1  instruction in EX is a conditional branch
taken_e  in  1  resolved branch condition in EX
target_e  in  XLEN  resolved branch target in EX
mispredict_e  out  1  EX branch mispredicted (combinational)
flush_d  out  1  kill ID instruction (= mispredict_e)
flush_e  out  1  kill EX-bound instruction (= mispredict_e | flush_e_in)
redirect_pc  out  XLEN  corrected fetch PC, valid when mispredict_e=1
upd_valid  out  1  registered: branch resolved last cycle
branch_taken  out  1  registered actual outcome, drives predictor training input
branch_cnt  out  CNT_W  resolved branches, saturating
mispred_cnt  out  CNT_W  mispredictions, saturating

Behaviour:
- Internal registers: D = {valid_d, pc_d, pred_d, tgt_d}, E = {valid_e, pc_e, pred_e, tgt_e}.
- Reset (synchronous, next rising edge with reset=1): valid_d=valid_e=0, upd_valid=0, branch_taken=0, branch_cnt=mispred_cnt=0; pc/tgt fields cleared to 0.
- F->D edge: if mispredict_e, valid_d<=0; else if stall_d, hold; else load {valid_f, pc_f, pred_taken_f, pred_target_f}.
- D->E edge: if mispredict_e or flush_e_in, valid_e<=0 (bubble); else load D. When stall_d=1, the hazard unit asserts flush_e_in; stall_d alone still copies D.
- mispredict_e = valid_e & branch_e & ((taken_e != pred_e) | (taken_e & pred_e & target_e != tgt_e)). Combinational, same cycle as EX.
- redirect_pc = taken_e ? target_e : pc_e + 4 (modulo 2^XLEN; wraps at all-ones). Driven 0 when mispredict_e=0.
- flush_d = mispredict_e. flush_e = mispredict_e | flush_e_in.
- Mispredict has priority over stall_d on the same edge.
- Training, 1-cycle latency: upd_valid <= valid_e & branch_e; branch_taken <= taken_e when valid_e & branch_e, otherwise holds its previous value. Holding is required because the predictor has no enable and samples branch_taken every cycle; bubbles must not retrain it in the opposite direction.
- Counters increment on the edge after EX resolution (same timing as upd_valid). branch_cnt += valid_e & branch_e; mispred_cnt += mispredict_e. Both saturate at all-ones with no wrap.
- branch_e / taken_e / target_e are ignored when valid_e=0.
- Reset mid-flight discards D/E contents; no update is emitted for them.

Test Plan:
- Reset: assert reset 2 cycles with valid_f=1 -> valid_d=valid_e=0, upd_valid=0, counters 0, mispredict_e=0.
- Correct not-taken: pc_f=0x100, pred_taken_f=0, 2 cycles later branch_e=1, taken_e=0 -> mispredict_e=0; next cycle upd_valid=1, branch_taken=0, branch_cnt=1.
- Direction mispredict: pc_f=0x200, pred=0, EX taken_e=1, target_e=0x180 -> mispredict_e=flush_d=flush_e=1, redirect_pc=0x180; next edge valid_d=valid_e=0, mispred_cnt=1.
- Target mispredict plus wrap: pred=1, tgt=0x300, EX taken_e=1, target_e=0x304 -> mispredict, redirect_pc=0x304. Separately, pc=0xFFFFFFFC, pred=1, taken_e=0 -> redirect_pc=0x00000000.
- Stall vs flush: stall_d=1 with flush_e_in=1 for 2 cycles -> D held, E bubbles, upd_valid=0, branch_taken unchanged. Mispredict with stall_d=1 -> valid_d cleared.
- Saturation: with CNT_W=4, run 20 mispredicting branches -> branch_cnt=mispred_cnt=15, held.
